// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32/RV64 immediate generator with 2-entry skid buffer
// Optional macro IMM_GEN_ERR_CNT_EN adds the saturating illegal-pop counter err_cnt.
module imm_gen_pipe #(
    parameter int          XLEN   = 32,
    parameter int          TAG_W  = 5,
    parameter logic [6:0]  LUI_OP = 7'h37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state;
    logic [XLEN-1:0]    skid_imm;
    logic [2:0]         skid_fmt;
    logic               skid_illegal;
    logic [TAG_W-1:0]   skid_tag;

    logic [6:0]         opcode;
    logic [31:0]        imm32;
    logic [2:0]         dec_fmt;
    logic               dec_illegal;
    logic [XLEN-1:0]    dec_imm;
    logic               acc;
    logic               pop;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // Every format keeps instr[31] as bit 31 of imm32, so one signed widen covers XLEN=64.
    always_comb begin
        opcode      = in_instr[6:0];
        imm32       = '0;
        dec_fmt     = 3'd0;
        dec_illegal = 1'b0;
        if (opcode == LUI_OP || opcode == 7'h17) begin
            imm32   = {in_instr[31:12], 12'b0};
            dec_fmt = 3'd4;
        end else if (opcode == 7'h03 || opcode == 7'h13 || opcode == 7'h1B || opcode == 7'h67) begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_fmt = 3'd1;
        end else if (opcode == 7'h23) begin
            imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec_fmt = 3'd2;
        end else if (opcode == 7'h63) begin
            imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
            dec_fmt = 3'd3;
        end else if (opcode == 7'h6F) begin
            imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
            dec_fmt = 3'd5;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    assign dec_imm = XLEN'(signed'(imm32));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            out_valid    <= 1'b0;
            in_ready     <= 1'b1;
            out_imm      <= '0;
            out_fmt      <= 3'd0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= 3'd0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        out_imm     <= dec_imm;
                        out_fmt     <= dec_fmt;
                        out_illegal <= dec_illegal;
                        out_tag     <= in_tag;
                        out_valid   <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        skid_imm     <= dec_imm;
                        skid_fmt     <= dec_fmt;
                        skid_illegal <= dec_illegal;
                        skid_tag     <= in_tag;
                        in_ready     <= 1'b0;
                        state        <= TWO;
                    end else if (acc && pop) begin
                        out_imm     <= dec_imm;
                        out_fmt     <= dec_fmt;
                        out_illegal <= dec_illegal;
                        out_tag     <= in_tag;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        out_imm     <= skid_imm;
                        out_fmt     <= skid_fmt;
                        out_illegal <= skid_illegal;
                        out_tag     <= skid_tag;
                        in_ready    <= 1'b1;
                        state       <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef IMM_GEN_ERR_CNT_EN
    // A pop coinciding with flush still consumed the entry, so flush is ignored here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 16'd0;
        end else if (pop && out_illegal && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN 32 and 64)
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [4:0]  out_tag;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [4:0]  out_tag64;
`ifdef IMM_GEN_ERR_CNT_EN
    logic [15:0] err_cnt, err_cnt64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef IMM_GEN_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
`ifdef IMM_GEN_ERR_CNT_EN
        , .err_cnt(err_cnt64)
`endif
    );

    task automatic drive(input logic v, input logic [31:0] instr, input logic [4:0] tag);
        in_valid = v;
        in_instr = instr;
        in_tag   = tag;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_imm !== 32'h0) begin errors++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
        checks++; if (out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_tag !== 5'd0) begin
            errors++; $display("FAIL reset_fields got fmt=%0d ill=%b tag=%0d want 0/0/0", out_fmt, out_illegal, out_tag); end
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        @(posedge clk); #1 drive(1'b1, 32'hFFF00093, 5'd1);
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", out_valid); end
        checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
        checks++; if (out_fmt !== 3'd1 || out_illegal !== 1'b0 || out_tag !== 5'd1) begin
            errors++; $display("FAIL addi_fields got fmt=%0d ill=%b tag=%0d want 1/0/1", out_fmt, out_illegal, out_tag); end
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] instrs [3];
        logic [31:0] imms   [3];
        logic [2:0]  fmts   [3];
        instrs = '{32'hFE112E23, 32'hFE000CE3, 32'h0010006F};
        imms   = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000800};
        fmts   = '{3'd2, 3'd3, 3'd5};
        out_ready = 1'b1;
        @(posedge clk); #1 drive(1'b1, instrs[0], 5'd10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 if (i < 2) drive(1'b1, instrs[i+1], 5'(11 + i)); else drive(1'b0, 32'h0, 5'd0);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_imm !== imms[i] || out_fmt !== fmts[i] || out_tag !== 5'(10 + i)) begin
                errors++; $display("FAIL b2b_%0d got v=%b imm=%h fmt=%0d tag=%0d want 1 %h %0d %0d",
                                   i, out_valid, out_imm, out_fmt, out_tag, imms[i], fmts[i], 10 + i); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %b want 1", i, in_ready); end
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_lui64;
        out_ready = 1'b1;
        @(posedge clk); #1 drive(1'b1, 32'h800002B7, 5'd2);
        @(posedge clk); #1 drive(1'b1, 32'h123452B7, 5'd3);
        @(negedge clk);
        checks++; if (out_imm64 !== 64'hFFFFFFFF80000000 || out_fmt64 !== 3'd4) begin
            errors++; $display("FAIL lui64_neg got %h fmt=%0d want ffffffff80000000 4", out_imm64, out_fmt64); end
        checks++; if (out_imm !== 32'h80000000 || out_fmt !== 3'd4) begin
            errors++; $display("FAIL lui32_neg got %h fmt=%0d want 80000000 4", out_imm, out_fmt); end
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(negedge clk);
        checks++; if (out_imm64 !== 64'h0000000012345000 || out_tag64 !== 5'd3) begin
            errors++; $display("FAIL lui64_pos got %h tag=%0d want 0000000012345000 3", out_imm64, out_tag64); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 32'h00500093, 5'd3);
        @(posedge clk); #1 drive(1'b1, 32'hFFF00093, 5'd4);
        @(posedge clk); #1 drive(1'b1, 32'h123452B7, 5'd5);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h5 || out_tag !== 5'd3) begin
            errors++; $display("FAIL bp_head got v=%b imm=%h tag=%0d want 1 5 3", out_valid, out_imm, out_tag); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_imm !== 32'h5 || out_fmt !== 3'd1 || out_tag !== 5'd3 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stable got imm=%h fmt=%0d tag=%0d rdy=%b want 5 1 3 0", out_imm, out_fmt, out_tag, in_ready); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (out_imm !== 32'hFFFFFFFF || out_tag !== 5'd4 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second got imm=%h tag=%0d rdy=%b want ffffffff 4 1", out_imm, out_tag, in_ready); end
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_fmt !== 3'd4 || out_tag !== 5'd5) begin
            errors++; $display("FAIL bp_third got v=%b imm=%h fmt=%0d tag=%0d want 1 12345000 4 5", out_valid, out_imm, out_fmt, out_tag); end
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 32'h00100093, 5'd6);
        @(posedge clk); #1 drive(1'b1, 32'h00200093, 5'd7);
        @(posedge clk); #1 begin drive(1'b1, 32'h00300093, 5'd8); flush = 1'b1; end
        @(posedge clk); #1 begin drive(1'b0, 32'h0, 5'd0); flush = 1'b0; end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_two got v=%b rdy=%b want 0 1", out_valid, in_ready); end
        // Flush in ONE while an input is accepted: that input must be discarded too.
        @(posedge clk); #1 drive(1'b1, 32'h00400093, 5'd9);
        @(posedge clk); #1 begin drive(1'b1, 32'h00500093, 5'd10); flush = 1'b1; end
        @(posedge clk); #1 begin drive(1'b0, 32'h0, 5'd0); flush = 1'b0; out_ready = 1'b1; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet_%0d got v=%b tag=%0d want 0", i, out_valid, out_tag); end
            @(posedge clk);
        end
        #1 drive(1'b1, 32'h00700093, 5'd11);
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h7 || out_tag !== 5'd11) begin
            errors++; $display("FAIL flush_after got v=%b imm=%h tag=%0d want 1 7 11", out_valid, out_imm, out_tag); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 32'hFFF00093, 5'd12);
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'h0 || out_tag !== 5'd0) begin
            errors++; $display("FAIL async_reset got v=%b rdy=%b imm=%h tag=%0d want 0 1 0 0", out_valid, in_ready, out_imm, out_tag); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_illegal;
`ifdef IMM_GEN_ERR_CNT_EN
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL errcnt_start got %0d want 0", err_cnt); end
`endif
        out_ready = 1'b0;
        @(posedge clk); #1 drive(1'b1, 32'h0000007F, 5'd13);
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_fmt !== 3'd0 || out_imm !== 32'h0) begin
            errors++; $display("FAIL illegal got v=%b ill=%b fmt=%0d imm=%h want 1 1 0 0", out_valid, out_illegal, out_fmt, out_imm); end
`ifdef IMM_GEN_ERR_CNT_EN
        @(posedge clk); @(negedge clk);
        checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL errcnt_no_pop got %0d want 0", err_cnt); end
        out_ready = 1'b1;
        @(posedge clk); #1 drive(1'b1, 32'h00100093, 5'd14);
        @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0);
        @(posedge clk); @(negedge clk);
        checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL errcnt_pop got %0d want 1", err_cnt); end
`else
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL illegal_pop got v=%b want 0", out_valid); end
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_lui64();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
